// File: rtl/imuldiv_muldiv_writeback_pkg.sv
// rtl/imuldiv_muldiv_writeback_pkg.sv - shared function codes and word-select helper
//
// Purpose : function-code constants of the mul/div request message, the tag
//           width macro (function code + destination address) and the helper
//           that picks the 32-bit writeback word out of the 64-bit result.
// Ports   : none (package).
// Macros  : IMULDIV_TAG_W(aw) - width of one {fn, waddr} tag.

`define IMULDIV_TAG_W(aw) (3 + (aw))

package imuldiv_muldiv_writeback_pkg;

  localparam int unsigned FN_W = 3;

  typedef enum logic [FN_W-1:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } muldiv_fn_e;

  typedef struct packed {
    logic [31:0] data;
    logic        bad;   // function code has no defined result word
  } wb_sel_t;

  // Low word carries product/quotient, high word carries remainder.
  function automatic wb_sel_t select_word(input logic [FN_W-1:0] fn,
                                          input logic [63:0]     result);
    wb_sel_t s;
    s.data = 32'h0;
    s.bad  = 1'b0;
    case (fn)
      FN_MUL, FN_DIV, FN_DIVU: s.data = result[31:0];
      FN_REM, FN_REMU:         s.data = result[63:32];
      default:                 s.bad  = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_writeback_if.sv
// rtl/imuldiv_muldiv_writeback_if.sv - request snoop, response and writeback bundle
//
// Purpose : groups the three handshakes seen by the writeback stage.
// Signals : req_val/req_rdy/req_fn/req_waddr   snooped issue handshake
//           issue_stall                        tag FIFO full
//           muldivresp_msg_result/_val/_rdy    unit response
//           wb_val/wb_rdy/wb_data/wb_waddr     register writeback
// Modports: slave  - the writeback stage
//           master - the surrounding pipeline / environment

interface imuldiv_muldiv_writeback_if #(
  parameter int AW = 5
) ();
  logic          req_val;
  logic          req_rdy;
  logic [2:0]    req_fn;
  logic [AW-1:0] req_waddr;
  logic          issue_stall;

  logic [63:0]   muldivresp_msg_result;
  logic          muldivresp_val;
  logic          muldivresp_rdy;

  logic          wb_val;
  logic          wb_rdy;
  logic [31:0]   wb_data;
  logic [AW-1:0] wb_waddr;

  modport slave (
    input  req_val, req_rdy, req_fn, req_waddr,
    input  muldivresp_msg_result, muldivresp_val,
    input  wb_rdy,
    output issue_stall, muldivresp_rdy,
    output wb_val, wb_data, wb_waddr
  );

  modport master (
    output req_val, req_rdy, req_fn, req_waddr,
    output muldivresp_msg_result, muldivresp_val,
    output wb_rdy,
    input  issue_stall, muldivresp_rdy,
    input  wb_val, wb_data, wb_waddr
  );
endinterface

// File: rtl/imuldiv_tag_fifo.sv
// rtl/imuldiv_tag_fifo.sv - synchronous tag FIFO for in-flight mul/div ops
//
// Purpose : DEPTH-entry FIFO (DEPTH a power of two, >= 2), head visible on
//           o_rdata. A push while full is accepted only if a pop happens in
//           the same cycle; otherwise it is dropped and flagged.
// Ports   : clk, reset (async, active low)
//           i_push, i_wdata   write side
//           i_pop, o_rdata    read side (pop ignored when empty)
//           o_full, o_empty   occupancy flags
//           o_push_drop       push lost because the FIFO was full

module imuldiv_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_push_drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_pop_ok    = i_pop && !o_empty;
  // A simultaneous pop frees the slot the push needs.
  assign w_push_ok   = i_push && (!o_full || w_pop_ok);
  assign o_push_drop = i_push && !w_push_ok;
  assign o_rdata     = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/imuldiv_muldiv_writeback.sv
// rtl/imuldiv_muldiv_writeback.sv - mul/div result writeback stage
//
// Purpose : records {fn, waddr} of each accepted mul/div request, pairs it
//           with the returning 64-bit result, and presents the selected
//           32-bit word on a val/rdy writeback port.
// Ports   : clk    clock, rising edge
//           reset  asynchronous active-low reset
//           bus    imuldiv_muldiv_writeback_if.slave (request snoop,
//                  issue_stall, response, writeback)
//           o_err  sticky protocol error (overflow push, orphan response,
//                  unknown function code); cleared only by reset
// Params  : DEPTH  tag FIFO entries (power of two, >= 2)
//           AW     destination register address width
// Config  : IMULDIV_WB_BYPASS_EN - when defined, a response arriving while
//           the output register is empty is forwarded in the same cycle.

module imuldiv_muldiv_writeback
  import imuldiv_muldiv_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  imuldiv_muldiv_writeback_if.slave    bus,
  output logic                         o_err
);
  localparam int TW = `IMULDIV_TAG_W(AW);

  logic          r_wb_val;
  logic [31:0]   r_wb_data;
  logic [AW-1:0] r_wb_waddr;
  logic          r_err;

  logic          w_push;
  logic          w_resp_rdy;
  logic          w_resp_fire;
  logic          w_pop;
  logic          w_orphan;
  logic          w_full;
  logic          w_empty;
  logic          w_push_drop;
  logic [TW-1:0] w_head;
  logic [2:0]    w_head_fn;
  logic [AW-1:0] w_head_waddr;
  wb_sel_t       w_sel;
  logic          w_err_set;

  assign w_push      = bus.req_val && bus.req_rdy;
  // Output register is refilled in the same cycle it drains.
  assign w_resp_rdy  = !r_wb_val || bus.wb_rdy;
  assign w_resp_fire = bus.muldivresp_val && w_resp_rdy;
  assign w_pop       = w_resp_fire && !w_empty;
  // Consumed anyway so the unit never stalls on a response nobody asked for.
  assign w_orphan    = w_resp_fire && w_empty;

  imuldiv_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_wdata     ({bus.req_fn, bus.req_waddr}),
    .i_pop       (w_resp_fire),
    .o_rdata     (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_push_drop (w_push_drop)
  );

  assign w_head_fn    = w_head[TW-1:AW];
  assign w_head_waddr = w_head[AW-1:0];
  assign w_sel        = select_word(w_head_fn, bus.muldivresp_msg_result);
  assign w_err_set    = w_push_drop || w_orphan || (w_pop && w_sel.bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_val   <= 1'b0;
      r_wb_data  <= 32'h0;
      r_wb_waddr <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
`ifdef IMULDIV_WB_BYPASS_EN
      // With an empty register the word goes out directly; keep it only
      // if the sink did not take it.
      if (w_pop && (r_wb_val || !bus.wb_rdy)) begin
        r_wb_val   <= 1'b1;
        r_wb_data  <= w_sel.data;
        r_wb_waddr <= w_head_waddr;
      end else if (r_wb_val && bus.wb_rdy) begin
        r_wb_val   <= 1'b0;
      end
`else
      if (w_pop) begin
        r_wb_val   <= 1'b1;
        r_wb_data  <= w_sel.data;
        r_wb_waddr <= w_head_waddr;
      end else if (bus.wb_rdy) begin
        r_wb_val   <= 1'b0;
      end
`endif
    end
  end

`ifdef IMULDIV_WB_BYPASS_EN
  logic w_bypass;
  assign w_bypass     = w_pop && !r_wb_val;
  assign bus.wb_val   = r_wb_val || w_bypass;
  assign bus.wb_data  = w_bypass ? w_sel.data   : r_wb_data;
  assign bus.wb_waddr = w_bypass ? w_head_waddr : r_wb_waddr;
`else
  assign bus.wb_val   = r_wb_val;
  assign bus.wb_data  = r_wb_data;
  assign bus.wb_waddr = r_wb_waddr;
`endif

  assign bus.muldivresp_rdy = w_resp_rdy;
  assign bus.issue_stall    = w_full;
  assign o_err              = r_err;

endmodule
